// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its word packer.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_BYTES_PER_WORD = 4;

    // Packer FSM: FILL accepts bytes, HOLD parks a finished word for the output register.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

endpackage

// File: rtl/fifo_word_packer.sv
// Drains bytes from a synchronous FIFO and packs them little-endian into
// words on a valid/ready stream; flush emits a partial word with a keep mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 fifo_empty,
    input  logic [DATA_WIDTH-1:0]                fifo_dout,
    output logic                                 fifo_rd_en,
    input  logic                                 flush,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] m_data,
    output logic [BYTES_PER_WORD-1:0]            m_keep,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 busy
);

    localparam int N  = BYTES_PER_WORD;
    localparam int CW = $clog2(N + 1);

    logic [N-1:0][DATA_WIDTH-1:0] asm_q, asm_c, ld_data;
    logic [N-1:0]                 ld_keep;
    logic [CW-1:0]                cnt, cnt_c, cnt_n;
    logic                         pending, flush_req, fr_n;
    logic                         out_free, load;
    pack_state_e                  state, state_n;

    assign out_free = !m_valid || m_ready;

    // Read only while filling, with room for every byte already in flight.
    // Gated by rst_n so no strobe reaches the FIFO while held in reset.
    assign fifo_rd_en = rst_n && (state == FILL) && !fifo_empty && !flush_req && !flush &&
                        (((CW+1)'(cnt) + (CW+1)'(pending)) < (CW+1)'(N));

    assign busy = (cnt != '0) || pending || m_valid || flush_req;

    // Land the byte read last cycle into lane cnt.
    always_comb begin
        asm_c = asm_q;
        cnt_c = cnt;
        for (int i = 0; i < N; i++) begin
            if (pending && cnt == CW'(i)) asm_c[i] = fifo_dout;
        end
        if (pending) cnt_c = cnt + CW'(1);
    end

    // Output word image: lanes past the fill count are zeroed, keep marks the rest.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ld_keep[i] = CW'(i) < cnt_c;
            ld_data[i] = ld_keep[i] ? asm_c[i] : '0;
        end
    end

    // Next-state decisions: emit full words, resolve flushes once nothing is in flight.
    always_comb begin
        load    = 1'b0;
        state_n = state;
        cnt_n   = cnt_c;
        fr_n    = flush_req || flush;
        case (state)
            FILL: begin
                if (cnt_c == CW'(N)) begin
                    // A full word keeps any flush request alive; it clears next cycle at cnt = 0.
                    if (out_free) begin
                        load  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        state_n = HOLD;
                    end
                end else if (flush_req && !pending) begin
                    if (cnt == '0) begin
                        fr_n = 1'b0;
                    end else if (out_free) begin
                        load  = 1'b1;
                        cnt_n = '0;
                        fr_n  = 1'b0;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    load    = 1'b1;
                    cnt_n   = '0;
                    state_n = FILL;
                    if (cnt != CW'(N)) fr_n = 1'b0;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // State and registered output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q     <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            flush_req <= 1'b0;
            state     <= FILL;
            m_data    <= '0;
            m_keep    <= '0;
            m_valid   <= 1'b0;
        end else begin
            asm_q     <= asm_c;
            cnt       <= cnt_n;
            pending   <= fifo_rd_en;
            flush_req <= fr_n;
            state     <= state_n;
            if (load) begin
                m_data  <= ld_data;
                m_keep  <= ld_keep;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural FIFO upstream, scoreboard downstream.
module tb_fifo_word_packer;

    logic        clk, rst_n, flush, m_ready, fifo_empty, fifo_rd_en;
    logic        m_valid, busy, wr_en;
    logic [7:0]  fifo_dout, wr_data;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    fifo_word_packer #(.DATA_WIDTH(8), .BYTES_PER_WORD(4)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
        .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Simple FIFO with registered read data and registered pointers.
    logic [7:0] mem [32];
    int wp = 0, rp = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp % 32] <= wr_data;
            wp <= wp + 1;
        end
        if (fifo_rd_en && wp != rp) begin
            fifo_dout <= mem[rp % 32];
            rp <= rp + 1;
        end
    end

    typedef struct { logic [31:0] d; logic [3:0] k; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, t_rd = -1, t_v = -1;
    logic lat_arm = 0;
    logic hold_prev = 0;
    logic [35:0] prev_out = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k);
        exp_t e;
        e.d = d;
        e.k = k;
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lat_arm && fifo_rd_en && t_rd < 0) t_rd <= cyc;
        if (lat_arm && m_valid && t_v < 0) t_v <= cyc;
    end

    // Monitor: pop on every accepted word, and check stability under backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && hold_prev) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_stable", {m_keep, m_data}, prev_out);
        end
        if (rst_n && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h keep %0h expected none", m_data, m_keep);
            end else begin
                e = sb.pop_front();
                chk("word_data", m_data, e.d);
                chk("word_keep", m_keep, e.k);
            end
        end
        hold_prev <= rst_n && m_valid && !m_ready;
        prev_out  <= {m_keep, m_data};
    end

    // Entered and left at posedge+1.
    task automatic wr(input logic [7:0] b);
        wr_en = 1;
        wr_data = b;
        @(posedge clk); #1;
        wr_en = 0;
    endtask

    task automatic wait_idle(input string nm);
        logic ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && fifo_empty && sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(nm, ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; flush = 0; m_ready = 1; wr_en = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_keep", m_keep, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Two full words at full throughput, plus first-word latency.
        lat_arm = 1;
        push_exp(32'h44332211, 4'hF);
        push_exp(32'h88776655, 4'hF);
        for (int i = 0; i < 8; i++) wr(8'(8'h11 * (i + 1)));
        wait_idle("idle_t1");
        chk("latency", 64'(t_v - t_rd), 5);
        lat_arm = 0;

        // Three bytes then flush: partial word keep 7.
        push_exp(32'h00A3A2A1, 4'h7);
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        repeat (6) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        wait_idle("idle_t2");
        chk("flush_busy_clear", busy, 0);

        // Backpressure: first word held, second in HOLD, four bytes left behind.
        m_ready = 0;
        push_exp(32'h34333231, 4'hF);
        push_exp(32'h38373635, 4'hF);
        push_exp(32'h3C3B3A39, 4'hF);
        for (int i = 0; i < 12; i++) wr(8'(8'h31 + i));
        repeat (20) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("bp_rd_en", fifo_rd_en, 0);
        chk("bp_fifo_left", 64'(wp - rp), 4);
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 32'h34333231);
        @(posedge clk); #1;
        m_ready = 1;
        wait_idle("idle_t3");

        // Flush in the cycle a read would issue with cnt = 1 and one byte in flight.
        push_exp(32'h0000C2C1, 4'h3);
        push_exp(32'h000000C3, 4'h1);
        wr(8'hC1); wr(8'hC2); wr(8'hC3);
        flush = 1;
        @(negedge clk);
        chk("flush_blocks_rd", fifo_rd_en, 0);
        @(posedge clk); #1;
        flush = 0;
        repeat (8) begin @(posedge clk); #1; end
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        wait_idle("idle_t4");

        // Flush with nothing assembled: no word, request clears the next cycle.
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        chk("empty_flush_req_set", busy, 1);
        @(negedge clk);
        chk("empty_flush_req_clear", busy, 0);
        chk("empty_flush_no_valid", m_valid, 0);
        @(posedge clk); #1;

        // Reset with a held word and two bytes assembled.
        m_ready = 0;
        for (int i = 0; i < 6; i++) wr(8'(8'h51 + i));
        repeat (15) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre_reset_valid", m_valid, 1);
        chk("pre_reset_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_keep", m_keep, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_ready = 1;
        push_exp(32'h04030201, 4'hF);
        for (int i = 0; i < 4; i++) wr(8'(i + 1));
        wait_idle("idle_t6");

        chk("sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
